led_blink_bank: RTL and testbench

- Multi-channel LED blinker driven from the board clock. It generalises the single free-running blink counter into CHANNELS independent LED outputs.
- Each channel has a runtime-selectable mode (off / on / blink / one-shot) and a half-period.
- A shared prescaler generates a slow tick so that every channel counts in visible-rate units.
- Sits between board top-level control logic (switches, keys, a CPU-style register writer) and the LEDG pins.

---
 rtl/led_blink_bank.sv | 118 +++++++++++
 tb/tb_led_blink_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_bank.sv
// led_blink_bank: multi-channel LED blinker with shared prescaler tick; optional PWM dimming under LED_BLINK_PWM_EN
module led_blink_bank #(
    parameter int CHANNELS = 8,
    parameter int TICK_DIV = 50000,
    parameter int DIV_W = 10,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_W-1:0]    cfg_div,
`ifdef LED_BLINK_PWM_EN
    input  logic [3:0]          cfg_duty,
`endif
    output logic                tick,
    output logic [CHANNELS-1:0] LEDG
);
    localparam int PRE_W = $clog2(TICK_DIV);
    typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, ONESHOT = 2'd3} mode_t;
    logic [PRE_W-1:0]    pre;
    mode_t               mode [CHANNELS];
    mode_t               mode_n [CHANNELS];
    logic [DIV_W-1:0]    div [CHANNELS];
    logic [DIV_W-1:0]    div_n [CHANNELS];
    logic [DIV_W-1:0]    cnt [CHANNELS];
    logic [DIV_W-1:0]    cnt_n [CHANNELS];
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] led_n;
    logic                wr_ok;
`ifdef LED_BLINK_PWM_EN
    logic [3:0]          pwm;
    logic [3:0]          pwm_n;
    logic [3:0]          duty [CHANNELS];
    logic [3:0]          duty_n [CHANNELS];
`endif
    assign wr_ok = cfg_we && (int'(cfg_ch) < CHANNELS);
    // prescaler wraps every TICK_DIV cycles; tick registers the wrap so channels see it on the next edge
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= (pre == PRE_W'(TICK_DIV - 1)) ? '0 : pre + PRE_W'(1);
            tick <= (pre == PRE_W'(TICK_DIV - 1));
        end
    end
    // per-channel next state: a valid write wins over the tick, otherwise the tick advances blink/one-shot timing
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_n[i] = mode[i];
            div_n[i]  = div[i];
            cnt_n[i]  = cnt[i];
            led_n[i]  = led[i];
`ifdef LED_BLINK_PWM_EN
            duty_n[i] = duty[i];
`endif
            if (wr_ok && int'(cfg_ch) == i) begin
                mode_n[i] = mode_t'(cfg_mode);
                div_n[i]  = cfg_div;
                cnt_n[i]  = '0;
                led_n[i]  = (cfg_mode != 2'd0);
`ifdef LED_BLINK_PWM_EN
                duty_n[i] = cfg_duty;
`endif
            end else if (tick) begin
                if (mode[i] == OFF || mode[i] == ON) begin
                    led_n[i] = (mode[i] == ON);
                    cnt_n[i] = '0;
                end else if (cnt[i] == div[i]) begin
                    led_n[i]  = (mode[i] == BLINK) ? !led[i] : 1'b0;
                    mode_n[i] = (mode[i] == BLINK) ? BLINK : OFF;
                    cnt_n[i]  = '0;
                end else begin
                    cnt_n[i] = cnt[i] + DIV_W'(1);
                end
            end
        end
    end
    // channel state registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            led <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode[i] <= OFF;
                div[i]  <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            led <= led_n;
            for (int i = 0; i < CHANNELS; i++) begin
                mode[i] <= mode_n[i];
                div[i]  <= div_n[i];
                cnt[i]  <= cnt_n[i];
            end
        end
    end
`ifdef LED_BLINK_PWM_EN
    assign pwm_n = pwm + 4'd1;
    // LEDG is registered from next-state values so dimming adds no write latency
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pwm  <= '0;
            LEDG <= '0;
            for (int i = 0; i < CHANNELS; i++) duty[i] <= 4'd15;
        end else begin
            pwm <= pwm_n;
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i] <= duty_n[i];
                LEDG[i] <= led_n[i] && (pwm_n < duty_n[i]);
            end
        end
    end
`else
    assign LEDG = led;
`endif
endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank: randomized and directed checks of led_blink_bank against a tick-counting reference model
module tb_led_blink_bank;
    localparam int CH = 6;
    localparam int TD = 4;
    localparam int DW = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          tick;
    logic [CH-1:0] ledg;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_mode [CH];
    int m_div [CH];
    int m_n [CH];

    always #5 clk = ~clk;

    led_blink_bank #(.CHANNELS(CH), .TICK_DIV(TD), .DIV_W(DW)) dut (
        .CLOCK_50(clk), .RESET(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_div(cfg_div), .tick(tick), .LEDG(ledg)
    );

    // LED level from mode and the number of ticks seen since the last write
    function automatic logic exp_led(int c);
        int p = m_div[c] + 1;
        case (m_mode[c])
            1: return 1'b1;
            2: return ((m_n[c] / p) % 2) == 0;
            3: return m_n[c] < p;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CH-1:0] exp_ledg();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = exp_led(c);
        return v;
    endfunction

    function automatic logic exp_tick();
        return cyc > 0 && cyc % TD == 0;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0;
            m_div[c] = 0;
            m_n[c] = 0;
        end
    endtask

    task automatic step();
        logic t = exp_tick();
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode);
                m_div[c] = int'(cfg_div);
                m_n[c] = 0;
            end else if (t) begin
                m_n[c]++;
            end
        end
        cyc++;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wr(int c, int m, int d);
        cfg_we = 1'b1;
        cfg_ch = 3'(c);
        cfg_mode = 2'(m);
        cfg_div = DW'(d);
        step();
    endtask

    task automatic run(int n, string name);
        for (int k = 0; k < n; k++) begin
            step();
            total++;
            if (ledg !== exp_ledg()) begin
                bad++;
                $display("FAIL %s ledg cyc=%0d got=%b want=%b", name, cyc, ledg, exp_ledg());
            end
            total++;
            if (tick !== exp_tick()) begin
                bad++;
                $display("FAIL %s tick cyc=%0d got=%b want=%b", name, cyc, tick, exp_tick());
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (ledg !== '0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL reset got ledg=%b tick=%b want 0 0", ledg, tick);
        end
        run(13, "reset_idle");
    endtask

    task automatic test_blink();
        wr(2, 2, 2);
        total++;
        if (ledg !== 6'b000100) begin
            bad++;
            $display("FAIL blink_start got=%b want=000100", ledg);
        end
        run(40, "blink");
    endtask

    task automatic test_oneshot();
        wr(0, 3, 1);
        total++;
        if (ledg[0] !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_start got=%b want=1", ledg[0]);
        end
        run(30, "oneshot");
        total++;
        if (ledg[0] !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_end got=%b want=0", ledg[0]);
        end
    endtask

    task automatic test_collision();
        wr(3, 2, 1);
        for (int k = 0; k < TD && !exp_tick(); k++) step();
        total++;
        if (tick !== 1'b1) begin
            bad++;
            $display("FAIL collision_tick got=%b want=1", tick);
        end
        wr(1, 2, 0);
        total++;
        if (ledg[1] !== 1'b1) begin
            bad++;
            $display("FAIL collision_write got=%b want=1", ledg[1]);
        end
        run(TD - 1, "collision_hold");
        total++;
        if (ledg[1] !== 1'b1) begin
            bad++;
            $display("FAIL collision_hold got=%b want=1", ledg[1]);
        end
        run(1, "collision_toggle");
        total++;
        if (ledg[1] !== 1'b0) begin
            bad++;
            $display("FAIL collision_toggle got=%b want=0", ledg[1]);
        end
        run(20, "collision_after");
    endtask

    task automatic test_invalid();
        for (int c = 0; c < CH; c++) wr(c, 0, 0);
        wr(7, 1, 0);
        wr(6, 1, 0);
        total++;
        if (ledg !== 6'b000000) begin
            bad++;
            $display("FAIL invalid_ch got=%b want=000000", ledg);
        end
        wr(5, 1, 0);
        total++;
        if (ledg !== 6'b100000) begin
            bad++;
            $display("FAIL valid_ch5 got=%b want=100000", ledg);
        end
        run(10, "invalid_after");
    endtask

    task automatic test_mid_reset();
        wr(2, 2, 2);
        run(5, "pre_reset");
        #1 rst = 1'b1;
        #1;
        total++;
        if (ledg !== '0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got ledg=%b tick=%b want 0 0", ledg, tick);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(6, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(2) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 3'($urandom_range(7));
                cfg_mode = 2'($urandom_range(3));
                cfg_div = DW'($urandom_range(3));
            end
            run(1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_collision();
        test_invalid();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
